// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiply issue scheduler: RV32M decode constants,
// the tracking-entry layout and the default pipeline depth.
package mul_sched_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int MUL_LATENCY_DEFAULT = 2;
  localparam int MUL_TAG_W           = 5;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011
  } mul_funct3_e;

  typedef struct packed {
    logic                 valid;
    logic [MUL_TAG_W-1:0] tag;
    logic                 port;
  } mul_track_t;

  // funct3[2]=1 selects the divide group, which this unit does not execute
  function automatic logic is_mul_op(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == FUNCT7_MULDIV) && !insn[14];
  endfunction

endpackage

// File: rtl/mul_sched_arbiter.sv
// Two-way grant logic for the shared multiplier. MUL_SCHED_RR_EN selects
// round-robin with a priority register; otherwise pipe0 always wins.
module mul_sched_arbiter (
`ifdef MUL_SCHED_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef MUL_SCHED_RR_EN
  logic prio;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

  // Requests arrive pre-masked by hold/flush, so no grant means a frozen priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (|grant) begin
      prio <= grant[0];
    end
  end
`else
  assign grant = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/biriscv_mul_scheduler.sv
// Shares one multiplier between both issue pipes and tracks in-flight results.
// Define MUL_SCHED_RR_EN for round-robin arbitration (default: pipe0 priority).
module biriscv_mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
  parameter int TAG_W       = MUL_TAG_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][31:0]      req_opcode_i,
  input  logic [1:0][31:0]      req_ra_i,
  input  logic [1:0][31:0]      req_rb_i,
  input  logic [1:0][TAG_W-1:0] req_tag_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic                  mul_valid_o,
  output logic [31:0]           mul_opcode_o,
  output logic [31:0]           mul_ra_o,
  output logic [31:0]           mul_rb_o,
  output logic                  mul_hold_o,
  input  logic [31:0]           mul_value_i,
  output logic                  wb_valid_o,
  output logic [31:0]           wb_value_o,
  output logic [TAG_W-1:0]      wb_tag_o,
  output logic                  wb_port_o,
  output logic                  illegal_o
);

  logic             can_issue;
  logic [1:0]       req_eff;
  logic [1:0]       grant;
  logic             sel;
  logic             accept;
  logic             legal;
  logic [31:0]      sel_opcode;
  logic [31:0]      sel_ra;
  logic [31:0]      sel_rb;
  logic [TAG_W-1:0] sel_tag;

  mul_track_t track [MUL_LATENCY];

  assign can_issue = ~(hold_i | flush_i | rst_i);
  assign req_eff   = req_valid_i & {2{can_issue}};

  mul_sched_arbiter u_arbiter (
`ifdef MUL_SCHED_RR_EN
    .clk   (clk_i),
    .rst   (rst_i),
`endif
    .req   (req_eff),
    .grant (grant)
  );

  assign req_ready_o = grant;
  assign sel         = grant[1];
  assign accept      = |grant;
  assign sel_opcode  = req_opcode_i[sel];
  assign sel_ra      = req_ra_i[sel];
  assign sel_rb      = req_rb_i[sel];
  assign sel_tag     = req_tag_i[sel];
  assign legal       = is_mul_op(sel_opcode);

  assign mul_valid_o  = accept & legal;
  assign illegal_o    = accept & ~legal;
  assign mul_opcode_o = mul_valid_o ? sel_opcode : '0;
  assign mul_ra_o     = mul_valid_o ? sel_ra : '0;
  assign mul_rb_o     = mul_valid_o ? sel_rb : '0;
  assign mul_hold_o   = hold_i & ~rst_i;

  // Flush wins over hold so killed ops can never resurface once the stall lifts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        track[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        track[i].valid <= 1'b0;
      end
    end else if (!hold_i) begin
      track[0].valid <= mul_valid_o;
      track[0].tag   <= sel_tag;
      track[0].port  <= sel;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        track[i] <= track[i-1];
      end
    end
  end

  assign wb_valid_o = track[MUL_LATENCY-1].valid;
  assign wb_tag_o   = wb_valid_o ? track[MUL_LATENCY-1].tag : '0;
  assign wb_port_o  = wb_valid_o & track[MUL_LATENCY-1].port;
  assign wb_value_o = rst_i ? '0 : mul_value_i;

endmodule

// File: tb/tb_biriscv_mul_scheduler.sv
// Directed bench for biriscv_mul_scheduler with a behavioural 2-cycle multiplier.
// Expectations follow MUL_SCHED_RR_EN when it is defined for the build.
module tb_biriscv_mul_scheduler;
  import mul_sched_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][31:0] req_opcode;
  logic [1:0][31:0] req_ra;
  logic [1:0][31:0] req_rb;
  logic [1:0][4:0] req_tag;
  logic            hold;
  logic            flush;
  logic            mul_valid;
  logic [31:0]     mul_opcode;
  logic [31:0]     mul_ra;
  logic [31:0]     mul_rb;
  logic            mul_hold;
  logic [31:0]     mul_value;
  logic            wb_valid;
  logic [31:0]     wb_value;
  logic [4:0]      wb_tag;
  logic            wb_port;
  logic            illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  biriscv_mul_scheduler dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_opcode_i (req_opcode),
    .req_ra_i     (req_ra),
    .req_rb_i     (req_rb),
    .req_tag_i    (req_tag),
    .hold_i       (hold),
    .flush_i      (flush),
    .mul_valid_o  (mul_valid),
    .mul_opcode_o (mul_opcode),
    .mul_ra_o     (mul_ra),
    .mul_rb_o     (mul_rb),
    .mul_hold_o   (mul_hold),
    .mul_value_i  (mul_value),
    .wb_valid_o   (wb_valid),
    .wb_value_o   (wb_value),
    .wb_tag_o     (wb_tag),
    .wb_port_o    (wb_port),
    .illegal_o    (illegal)
  );

  // Reference arithmetic for the four RV32M multiply flavours
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'b000:  begin p = ua * ub; return p[31:0];  end
      3'b001:  begin p = sa * sb; return p[63:32]; end
      3'b010:  begin p = sa * ub; return p[63:32]; end
      3'b011:  begin p = ua * ub; return p[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  // Multiplier stand-in: two registered stages, frozen by its hold input, not reset
  logic [31:0] mdl_s1 = 32'h0;
  logic [31:0] mdl_s2 = 32'h0;
  assign mul_value = mdl_s2;

  always @(posedge clk) begin
    if (!mul_hold) begin
      if (mul_valid) mdl_s1 <= ref_mul(mul_opcode[14:12], mul_ra, mul_rb);
      mdl_s2 <= mdl_s1;
    end
  end

  function automatic logic [31:0] make_op(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OPC_OP};
  endfunction

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] op,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic [4:0] t0, input logic [4:0] t1,
                               input logic h, input logic f);
    req_valid     = v;
    req_opcode[0] = op;
    req_opcode[1] = op;
    req_ra[0]     = a0;
    req_rb[0]     = b0;
    req_ra[1]     = a1;
    req_rb[1]     = b1;
    req_tag[0]    = t0;
    req_tag[1]    = t1;
    hold          = h;
    flush         = f;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic        legal;
    logic [31:0] value;
  } vec_t;

  vec_t        vecs [6];
  logic [1:0]  exp_ready [4];
  logic        exp_port  [4];
  logic [31:0] mul_op;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b01, FUNCT7_MULDIV, F3_MUL,    32'h80000001, 32'h80010002, 5'd10, 1'b1, 32'h80010002};
    vecs[1] = '{2'b10, FUNCT7_MULDIV, F3_MULH,   32'h80000001, 32'h80010002, 5'd11, 1'b1, 32'h3FFF7FFE};
    vecs[2] = '{2'b10, FUNCT7_MULDIV, F3_MULHSU, 32'h80000001, 32'h80010002, 5'd12, 1'b1, 32'hBFFF7FFF};
    vecs[3] = '{2'b10, FUNCT7_MULDIV, F3_MULHU,  32'h80000001, 32'h80010002, 5'd13, 1'b1, 32'h40008001};
    vecs[4] = '{2'b01, 7'b0000000,    3'b000,    32'h00000005, 32'h00000006, 5'd14, 1'b0, 32'h0};
    vecs[5] = '{2'b10, FUNCT7_MULDIV, 3'b100,    32'h00000005, 32'h00000006, 5'd15, 1'b0, 32'h0};
`ifdef MUL_SCHED_RR_EN
    exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_port  = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ready = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_port  = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    mul_op = make_op(FUNCT7_MULDIV, F3_MUL);

    // Reset state, with a request pending to prove it is refused
    rst = 1'b1;
    idle();
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("rst ready", 32'(req_ready), 32'h0);
    checkOutput("rst mul_valid", 32'(mul_valid), 32'h0);
    checkOutput("rst wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("rst illegal", 32'(illegal), 32'h0);
    next_cycle();
    idle();
    next_cycle();
    rst = 1'b0;

    // Single operations, one per pipe, legal and illegal
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].valid, make_op(vecs[i].f7, vecs[i].f3), vecs[i].a, vecs[i].b,
                    vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].tag, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].valid));
      checkOutput($sformatf("v%0d mul_valid", i), 32'(mul_valid), 32'(vecs[i].legal));
      checkOutput($sformatf("v%0d illegal", i), 32'(illegal), 32'(!vecs[i].legal));
      next_cycle();
      idle();
      @(negedge clk);
      checkOutput($sformatf("v%0d wb_early", i), 32'(wb_valid), 32'h0);
      next_cycle();
      @(negedge clk);
      checkOutput($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].legal));
      if (vecs[i].legal) begin
        checkOutput($sformatf("v%0d wb_value", i), wb_value, vecs[i].value);
        checkOutput($sformatf("v%0d wb_tag", i), 32'(wb_tag), 32'(vecs[i].tag));
        checkOutput($sformatf("v%0d wb_port", i), 32'(wb_port), 32'(vecs[i].valid[1]));
      end
      next_cycle();
    end

    // Contention: both pipes request for four cycles from a fresh priority state
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) applyStimulus(2'b11, mul_op, 32'd3, 32'd5, 32'd7, 32'd11, 5'd1, 5'd2, 1'b0, 1'b0);
      else idle();
      @(negedge clk);
      if (c < 4) checkOutput($sformatf("arb c%0d ready", c), 32'(req_ready), 32'(exp_ready[c]));
      if (c >= 2) begin
        checkOutput($sformatf("arb c%0d wb_valid", c), 32'(wb_valid), 32'h1);
        checkOutput($sformatf("arb c%0d wb_port", c), 32'(wb_port), 32'(exp_port[c-2]));
        checkOutput($sformatf("arb c%0d wb_tag", c), 32'(wb_tag), exp_port[c-2] ? 32'd2 : 32'd1);
        checkOutput($sformatf("arb c%0d wb_value", c), wb_value, exp_port[c-2] ? 32'd77 : 32'd15);
      end
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();

    // Hold for three cycles after an issue stretches latency to five
    applyStimulus(2'b01, mul_op, 32'd6, 32'd7, 32'd0, 32'd0, 5'd9, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hold issue", 32'(mul_valid), 32'h1);
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(2'b11, mul_op, 32'd1, 32'd1, 32'd1, 32'd1, 5'd3, 5'd4, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("hold c%0d ready", c), 32'(req_ready), 32'h0);
      checkOutput($sformatf("hold c%0d mul_hold", c), 32'(mul_hold), 32'h1);
      checkOutput($sformatf("hold c%0d wb_valid", c), 32'(wb_valid), 32'h0);
      next_cycle();
    end
    idle();
    @(negedge clk);
    checkOutput("hold c4 wb_valid", 32'(wb_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    checkOutput("hold c5 wb_valid", 32'(wb_valid), 32'h1);
    checkOutput("hold c5 wb_value", wb_value, 32'd42);
    checkOutput("hold c5 wb_tag", 32'(wb_tag), 32'd9);
    next_cycle();
    @(negedge clk);
    checkOutput("hold c6 wb_valid", 32'(wb_valid), 32'h0);
    next_cycle();

    // Flush with two ops issued back-to-back from alternating pipes
    applyStimulus(2'b01, mul_op, 32'd2, 32'd2, 32'd0, 32'd0, 5'd4, 5'd0, 1'b0, 1'b0);
    next_cycle();
    applyStimulus(2'b10, mul_op, 32'd0, 32'd0, 32'd3, 32'd3, 5'd0, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flushA issue2", 32'(mul_valid), 32'h1);
    next_cycle();
    applyStimulus(2'b11, mul_op, 32'd1, 32'd1, 32'd1, 32'd1, 5'd6, 5'd6, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flushA ready", 32'(req_ready), 32'h0);
    checkOutput("flushA mul_valid", 32'(mul_valid), 32'h0);
    next_cycle();
    idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("flushA wb c%0d", c), 32'(wb_valid), 32'h0);
      next_cycle();
    end

    // Flush together with hold still kills the in-flight op
    applyStimulus(2'b01, mul_op, 32'd2, 32'd3, 32'd0, 32'd0, 5'd6, 5'd0, 1'b0, 1'b0);
    next_cycle();
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flushB ready", 32'(req_ready), 32'h0);
    next_cycle();
    idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("flushB wb c%0d", c), 32'(wb_valid), 32'h0);
      next_cycle();
    end

    // Asynchronous reset with two ops in flight
    applyStimulus(2'b01, mul_op, 32'd9, 32'd9, 32'd0, 32'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rstmid issue", 32'(mul_valid), 32'h1);
    next_cycle();
    applyStimulus(2'b10, mul_op, 32'd0, 32'd0, 32'd4, 32'd4, 5'd0, 5'd8, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid ready", 32'(req_ready), 32'h0);
    checkOutput("rstmid mul_valid", 32'(mul_valid), 32'h0);
    checkOutput("rstmid mul_opcode", mul_opcode, 32'h0);
    checkOutput("rstmid wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("rstmid wb_value", wb_value, 32'h0);
    checkOutput("rstmid wb_tag", 32'(wb_tag), 32'h0);
    checkOutput("rstmid illegal", 32'(illegal), 32'h0);
    next_cycle();
    idle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rstmid wb c%0d", c), 32'(wb_valid), 32'h0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
